// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op-class helpers shared by the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_NOR   = 5'b00111;
    localparam logic [4:0] ALU_LT    = 5'b01000;
    localparam logic [4:0] ALU_LE    = 5'b01001;
    localparam logic [4:0] ALU_NE    = 5'b01010;
    localparam logic [4:0] ALU_EQ    = 5'b01011;
    localparam logic [4:0] ALU_GT    = 5'b01100;
    localparam logic [4:0] ALU_GE    = 5'b01101;
    localparam logic [4:0] ALU_SRA   = 5'b01110;
    localparam logic [4:0] ALU_MUL   = 5'b10000;
    localparam logic [4:0] ALU_MULHU = 5'b10001;
    localparam logic [4:0] ALU_DIVU  = 5'b10010;
    localparam logic [4:0] ALU_REMU  = 5'b10011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_cmp(input logic [4:0] op);
        return op inside {ALU_LT, ALU_LE, ALU_NE, ALU_EQ, ALU_GT, ALU_GE};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider on a shared accumulator.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               div_q, hi_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   sh;

    // Mul: acc = {partial, multiplier}; div: acc = {remainder, quotient}. A zero divisor
    // always "fits", which naturally yields all-ones quotient and remainder = a.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        sh    = {acc_q, 1'b0};
        acc_d = div_q ? ((sh[2*WIDTH:WIDTH] >= {1'b0, b_q})
                         ? {sh[2*WIDTH-1:WIDTH] - b_q, sh[WIDTH-1:1], 1'b1} : sh[2*WIDTH-1:0])
                      : (acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]});
    end

    // The final step's result is presented combinationally so the caller can register it
    // on the same edge, giving WIDTH+1 cycles from accept to result.
    assign done   = cnt_q == CW'(1);
    assign result = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            hi_q  <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
            div_q <= op[1];
            hi_q  <= op[0];
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle ALU/compare ops and iterative mul/div behind valid/ready.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cond,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] result_q, res_d, md_result;
    logic             valid_q, cond_q, err_q, zero_q;
    logic             cond_d, err_d, md_op, md_start, md_done, accept;
    logic [SHW-1:0]   shamt;

    assign shamt    = in_b[SHW-1:0];
    assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign md_op    = ENABLE_MULDIV && is_muldiv(in_op);
    assign md_start = accept && md_op;

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_cond   = cond_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign busy       = state_q == S_BUSY;

    always_comb begin
        res_d  = '0;
        cond_d = 1'b0;
        err_d  = 1'b0;
        case (in_op)
            ALU_ADD: res_d = in_a + in_b;
            ALU_SUB: res_d = in_a - in_b;
            ALU_AND: res_d = in_a & in_b;
            ALU_OR:  res_d = in_a | in_b;
            ALU_XOR: res_d = in_a ^ in_b;
            ALU_SLL: res_d = in_a << shamt;
            ALU_SRL: res_d = in_a >> shamt;
            ALU_NOR: res_d = ~(in_a | in_b);
            ALU_SRA: res_d = $signed(in_a) >>> shamt;
            ALU_LT:  cond_d = in_a < in_b;
            ALU_LE:  cond_d = in_a <= in_b;
            ALU_NE:  cond_d = in_a != in_b;
            ALU_EQ:  cond_d = in_a == in_b;
            ALU_GT:  cond_d = in_a > in_b;
            ALU_GE:  cond_d = in_a >= in_b;
            default: err_d = 1'b1;
        endcase
        if (is_cmp(in_op)) res_d = {{(WIDTH-1){1'b0}}, cond_d};
    end

    if (ENABLE_MULDIV) begin : g_md
        muldiv_iter #(.WIDTH(WIDTH)) u_md (
            .clk    (clk),
            .rst    (rst),
            .start  (md_start),
            .op     (in_op[1:0]),
            .a      (in_a),
            .b      (in_b),
            .done   (md_done),
            .result (md_result)
        );
    end else begin : g_no_md
        assign md_done   = 1'b0;
        assign md_result = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            cond_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else if (accept && !md_op) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= res_d;
            cond_q   <= cond_d;
            err_q    <= err_d;
            zero_q   <= res_d == '0;
        end else if (accept) begin
            state_q  <= S_BUSY;
            valid_q  <= 1'b0;
        end else if (state_q == S_BUSY && md_done) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= md_result;
            cond_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= md_result == '0;
        end else if (state_q == S_DONE && out_ready) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with hand-computed results for alu_mc, plus a no-muldiv build.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
    logic [4:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, out_cond, out_zero, out_err, busy;
    logic [31:0] out_result;
    logic        in_ready0, out_valid0, out_cond0, out_zero0, out_err0, busy0;
    logic [31:0] out_result0;
    int          n_vec = 0, n_err = 0, n;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cond(out_cond), .out_zero(out_zero),
        .out_err(out_err), .busy(busy)
    );

    alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(1'b1),
        .out_result(out_result0), .out_cond(out_cond0), .out_zero(out_zero0),
        .out_err(out_err0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid",  {31'b0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_zero",   {31'b0, out_zero}, 32'd1);
        chk("rst_flags",  {29'b0, out_cond, out_err, busy}, 32'd0);
        chk("rst_ready",  {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        chk("add_valid_lat1", {31'b0, out_valid}, 32'd1);
        chk("add_result",     out_result, 32'd0);
        chk("add_zero_cond",  {30'b0, out_zero, out_cond}, 32'b10);
        tick();
        issue(ALU_SRA, 32'h8000_0000, 32'h24);
        chk("sra", out_result, 32'hF800_0000);
        issue(ALU_SRL, 32'h8000_0000, 32'h24);
        chk("srl", out_result, 32'h0800_0000);
        issue(ALU_LT, 32'd3, 32'd5);
        chk("lt_result", out_result, 32'd1);
        chk("lt_cond",   {31'b0, out_cond}, 32'd1);
        issue(ALU_GE, 32'd3, 32'd5);
        chk("ge_cond", {31'b0, out_cond}, 32'd0);
        issue(ALU_SUB, 32'd5, 32'd7);
        chk("sub_wrap", out_result, 32'hFFFF_FFFE);
        issue(ALU_NOR, 32'hF0F0_0000, 32'h0000_0F0F);
        chk("nor", out_result, 32'h0F0F_F0F0);
        tick();

        run_md(ALU_MUL, 32'hFFFF_FFFF, 32'd2);
        chk("mul_latency", n, 33);
        chk("mul_result",  out_result, 32'hFFFF_FFFE);
        tick();
        run_md(ALU_MULHU, 32'hFFFF_FFFF, 32'd2);
        chk("mulhu_result", out_result, 32'd1);
        tick();
        run_md(ALU_REMU, 32'd100, 32'd7);
        chk("remu", out_result, 32'd2);
        tick();
        run_md(ALU_DIVU, 32'd5, 32'd0);
        chk("divu_by0", out_result, 32'hFFFF_FFFF);
        tick();
        run_md(ALU_REMU, 32'd5, 32'd0);
        chk("remu_by0", out_result, 32'd5);
        tick();

        out_ready = 1'b0;
        issue(ALU_DIVU, 32'd100, 32'd7);
        chk("divu_busy", {30'b0, busy, in_ready}, 32'b10);
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("divu_latency", n, 33);
        chk("divu", out_result, 32'd14);
        in_valid = 1'b1;
        in_op    = ALU_ADD;
        in_a     = 32'd1;
        in_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_state", {29'b0, out_valid, in_ready, busy}, 32'b100);
            chk("hold_result", out_result, 32'd14);
        end
        out_ready = 1'b1;
        #1;
        chk("in_ready_follows_out_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("b2b_1", out_result, 32'd2);
        chk("b2b_1_valid", {31'b0, out_valid}, 32'd1);
        in_a = 32'd3;
        in_b = 32'd4;
        tick();
        chk("b2b_2", out_result, 32'd7);
        in_a = 32'd10;
        in_b = 32'd20;
        tick();
        chk("b2b_3", out_result, 32'd30);
        in_valid = 1'b0;
        tick();

        issue(ALU_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid_busy", {30'b0, out_valid, busy}, 32'd0);
        chk("midrst_result",     out_result, 32'd0);
        chk("midrst_zero_ready", {30'b0, out_zero, in_ready}, 32'b11);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("midrst_no_output", n, 0);
        issue(ALU_ADD, 32'd2, 32'd2);
        chk("post_rst_add", out_result, 32'd4);
        issue(5'b10101, 32'd9, 32'd9);
        chk("illegal_err",    {31'b0, out_err}, 32'd1);
        chk("illegal_result", out_result, 32'd0);
        tick();

        in_valid0 = 1'b1;
        in_op     = ALU_MUL;
        in_a      = 32'd6;
        in_b      = 32'd7;
        tick();
        in_valid0 = 1'b0;
        chk("nomd_valid",  {30'b0, out_valid0, busy0}, 32'b10);
        chk("nomd_err",    {31'b0, out_err0}, 32'd1);
        chk("nomd_result", out_result0, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
